// File: rtl/sht40_sequencer.sv
// sht40_sequencer: sequences one SHT40 measure-command write, conversion wait, 6-byte read and CRC check through an upstream i2c_master
// Ports: clk, rst (async, active high); start/busy request handshake;
//   proc_ready, peripheral_address, command_data_frames, r_or_w, i2c_writes, sht_reads, crc_error drive the master;
//   master_done, ack_error, rx_valid, rx_byte come back from it;
//   temp_raw, rh_raw, meas_valid publish results; err_code, err_pulse report failures.
module sht40_sequencer #(
   parameter logic [6:0] SHT_ADDR  = 7'h44,
   parameter logic [7:0] MEAS_CMD  = 8'hFD,
   parameter int         MEAS_WAIT = 20000,
   parameter int         TIMEOUT   = 65535
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        proc_ready,
   output logic [6:0]  peripheral_address,
   output logic [7:0]  command_data_frames,
   output logic        r_or_w,
   output logic [2:0]  i2c_writes,
   output logic [3:0]  sht_reads,
   output logic        crc_error,
   input  logic        master_done,
   input  logic        ack_error,
   input  logic        rx_valid,
   input  logic [7:0]  rx_byte,
   output logic        busy,
   output logic [15:0] temp_raw,
   output logic [15:0] rh_raw,
   output logic        meas_valid,
   output logic [1:0]  err_code,
   output logic        err_pulse
);
   localparam int WW = $clog2(MEAS_WAIT + 1);
   localparam logic [WW-1:0] W_LAST = WW'(MEAS_WAIT - 1);
   // master_done may still arrive TIMEOUT cycles after proc_ready; the counter hits 0 on that last allowed cycle
   localparam logic [15:0] T_LOAD = 16'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, CMD_REQ, CMD_WAIT, MEAS_WAIT_S, RD_REQ, RD_COLLECT, DONE, ERR} state_t;

   state_t        state, state_nxt;
   logic [15:0]   tmo;
   logic [WW-1:0] wait_cnt;
   logic [2:0]    idx, idx_nxt;
   logic [7:0]    rx_buf [6];
   logic [7:0]    crc, crc_upd;
   logic          store, crc_bad;
   logic [1:0]    code_nxt;

   function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
      logic [7:0] r;
      r = c ^ d;
      for (int i = 0; i < 8; i++) r = r[7] ? {r[6:0], 1'b0} ^ 8'h31 : {r[6:0], 1'b0};
      return r;
   endfunction

   assign proc_ready         = state == CMD_REQ || state == RD_REQ;
   assign busy               = state != IDLE;
   assign meas_valid         = state == DONE;
   assign err_pulse          = state == ERR;
   assign peripheral_address = SHT_ADDR;
   assign sht_reads          = 4'd5;
   assign i2c_writes         = r_or_w ? 3'd0 : 3'd1;

   // bytes 0/3 restart the CRC, bytes 2/5 are the checksums compared against the running value
   assign store   = state == RD_COLLECT && rx_valid && idx < 3'd6;
   assign crc_upd = crc8((idx == 3'd0 || idx == 3'd3) ? 8'hFF : crc, rx_byte);
   assign crc_bad = store && (idx == 3'd2 || idx == 3'd5) && rx_byte != crc;
   assign idx_nxt = idx + {2'b00, store};

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= state_nxt;

   // exit decisions use this cycle's byte and CRC result, so a byte arriving with master_done counts
   always_comb begin
      state_nxt = state;
      code_nxt  = 2'b00;
      case (state)
         IDLE:        if (start) state_nxt = CMD_REQ;
         CMD_REQ:     state_nxt = CMD_WAIT;
         CMD_WAIT:
            if (master_done) begin
               state_nxt = ack_error ? ERR : MEAS_WAIT_S;
               code_nxt  = 2'b01;
            end else if (tmo == 16'd0) begin
               state_nxt = ERR;
               code_nxt  = 2'b11;
            end
         MEAS_WAIT_S: if (wait_cnt == W_LAST) state_nxt = RD_REQ;
         RD_REQ:      state_nxt = RD_COLLECT;
         RD_COLLECT:
            if (master_done) begin
               state_nxt = (!crc_error && !crc_bad && !ack_error && idx_nxt == 3'd6) ? DONE : ERR;
               code_nxt  = (crc_error || crc_bad) ? 2'b10 : ack_error ? 2'b01 : 2'b11;
            end else if (tmo == 16'd0) begin
               state_nxt = ERR;
               code_nxt  = 2'b11;
            end
         default:     state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         tmo                 <= 16'd0;
         wait_cnt            <= '0;
         idx                 <= 3'd0;
         crc                 <= 8'h00;
         crc_error           <= 1'b0;
         r_or_w              <= 1'b0;
         command_data_frames <= 8'h00;
         temp_raw            <= 16'h0000;
         rh_raw              <= 16'h0000;
         err_code            <= 2'b00;
         rx_buf              <= '{default: 8'h00};
      end else begin
         tmo      <= (state == CMD_REQ || state == RD_REQ) ? T_LOAD : tmo != 16'd0 ? tmo - 16'd1 : tmo;
         wait_cnt <= state == MEAS_WAIT_S ? wait_cnt + WW'(1) : '0;
         if (state == IDLE && start) begin
            r_or_w              <= 1'b0;
            command_data_frames <= MEAS_CMD;
         end
         if (state == CMD_WAIT && state_nxt != CMD_WAIT) command_data_frames <= 8'h00;
         if (state == MEAS_WAIT_S && state_nxt == RD_REQ) begin
            r_or_w <= 1'b1;
            idx    <= 3'd0;
         end else idx <= idx_nxt;
         if (store) begin
            rx_buf[idx] <= rx_byte;
            crc         <= crc_upd;
         end
         crc_error <= (state == RD_COLLECT && state_nxt != RD_COLLECT) ? 1'b0 : crc_error | crc_bad;
         if (state_nxt == DONE) begin
            temp_raw <= {rx_buf[0], rx_buf[1]};
            rh_raw   <= {rx_buf[3], rx_buf[4]};
         end
         if (state_nxt == ERR) err_code <= code_nxt;
      end
endmodule

// File: tb/tb_sht40_sequencer.sv
// tb_sht40_sequencer: randomized master-emulating bench for sht40_sequencer with a transaction-level reference model
module tb_sht40_sequencer;
   localparam int MW = 50;
   localparam int TO = 100;

   logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic        master_done = 1'b0, ack_error = 1'b0, rx_valid = 1'b0;
   logic [7:0]  rx_byte = 8'h00;
   logic        proc_ready, r_or_w, crc_error, busy, meas_valid, err_pulse;
   logic [6:0]  peripheral_address;
   logic [7:0]  command_data_frames;
   logic [2:0]  i2c_writes;
   logic [3:0]  sht_reads;
   logic [15:0] temp_raw, rh_raw;
   logic [1:0]  err_code;

   int n_cmp = 0, n_bad = 0;
   int cyc = 0, pr_cnt = 0, mv_cnt = 0;
   logic [15:0] m_temp = 16'h0000, m_rh = 16'h0000;

   sht40_sequencer #(.MEAS_WAIT(MW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .start(start), .proc_ready(proc_ready),
      .peripheral_address(peripheral_address), .command_data_frames(command_data_frames),
      .r_or_w(r_or_w), .i2c_writes(i2c_writes), .sht_reads(sht_reads), .crc_error(crc_error),
      .master_done(master_done), .ack_error(ack_error), .rx_valid(rx_valid), .rx_byte(rx_byte),
      .busy(busy), .temp_raw(temp_raw), .rh_raw(rh_raw), .meas_valid(meas_valid),
      .err_code(err_code), .err_pulse(err_pulse)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc    <= cyc + 1;
      pr_cnt <= pr_cnt + (proc_ready ? 1 : 0);
      mv_cnt <= mv_cnt + (meas_valid ? 1 : 0);
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // CRC-8 as long division of (word ^ init) * x^8 by x^8+x^5+x^4+1
   function automatic logic [7:0] ref_crc(input logic [15:0] w);
      logic [23:0] r;
      r = {w ^ 16'hFF00, 8'h00};
      for (int p = 23; p >= 8; p--) if (r[p]) r[p -: 9] = r[p -: 9] ^ 9'h131;
      return r[7:0];
   endfunction

   task automatic finish_err(input int code);
      chk("err_pulse", err_pulse, 1);
      chk("err_code", err_code, code);
      chk("meas_valid_on_err", meas_valid, 0);
      chk("temp_kept", temp_raw, m_temp);
      chk("rh_kept", rh_raw, m_rh);
      @(negedge clk);
      chk("busy_after_err", busy, 0);
      chk("err_pulse_one_cycle", err_pulse, 0);
   endtask

   // kinds: 0 good, 1 corrupted byte, 2 cmd NACK, 3 cmd timeout, 4 read NACK,
   //        5 short read, 6 read timeout, 7 extra byte, 8 cmd done on last allowed cycle
   task automatic run_txn(input int kind, input bit fixed);
      logic [7:0]  b [7];
      logic [15:0] t, h;
      int nb, d, c0, c1, c2, pr0, mv0, code, stored, ci;
      logic ack_rd, sim, last, mism1, mism2, fault, reached;
      t = fixed ? 16'hBEEF : 16'($urandom);
      h = fixed ? 16'h6666 : 16'($urandom);
      b[0] = t[15:8]; b[1] = t[7:0]; b[2] = ref_crc(t);
      b[3] = h[15:8]; b[4] = h[7:0]; b[5] = ref_crc(h); b[6] = 8'($urandom);
      nb = kind == 5 ? $urandom_range(0, 5) : kind == 7 ? 7 : 6;
      if (kind == 1) begin
         ci = $urandom_range(0, 5);
         b[ci] = b[ci] ^ 8'($urandom_range(1, 255));
      end
      mism1   = b[2] != ref_crc({b[0], b[1]});
      mism2   = b[5] != ref_crc({b[3], b[4]});
      ack_rd  = kind == 4;
      sim     = 1'($urandom_range(0, 1));
      reached = 1'b0;
      pr0 = pr_cnt; mv0 = mv_cnt;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      c0 = cyc;
      chk("busy_after_start", busy, 1);
      chk("proc_ready_cmd", proc_ready, 1);
      chk("rw_cmd", r_or_w, 0);
      chk("frame_cmd", command_data_frames, 8'hFD);
      chk("writes_cmd", i2c_writes, 1);
      if (kind == 3) begin
         while (!err_pulse && cyc - c0 < 4 * TO) @(negedge clk);
         chk("cmd_timeout_cycles", cyc - c0, TO + 1);
         finish_err(3);
      end else begin
         d = kind == 8 ? TO : $urandom_range(1, 20);
         repeat (d) @(negedge clk);
         master_done = 1'b1; ack_error = kind == 2;
         c1 = cyc;
         @(negedge clk);
         master_done = 1'b0; ack_error = 1'b0;
         if (kind == 2) finish_err(1);
         else begin
            reached = 1'b1;
            while (!proc_ready && cyc - c1 < 4 * MW) begin
               start = $urandom_range(0, 3) == 0;
               @(negedge clk);
            end
            start = 1'b0;
            c2 = cyc;
            chk("meas_wait_len", cyc - c1, MW + 1);
            chk("busy_read", busy, 1);
            chk("rw_read", r_or_w, 1);
            chk("frame_read", command_data_frames, 8'h00);
            chk("writes_read", i2c_writes, 0);
            chk("sht_reads", sht_reads, 5);
            chk("addr", peripheral_address, 7'h44);
            for (int k = 0; k < nb; k++) begin
               repeat ($urandom_range(1, 3)) @(negedge clk);
               rx_valid = 1'b1; rx_byte = b[k];
               last = k == nb - 1 && sim && kind != 6;
               if (last) begin
                  master_done = 1'b1; ack_error = ack_rd;
               end
               @(negedge clk);
               rx_valid = 1'b0; master_done = 1'b0; ack_error = 1'b0;
               if (!last) chk("crc_error_flag", crc_error, (k >= 2 && mism1) || (k >= 5 && mism2));
            end
            stored = nb > 6 ? 6 : nb;
            fault  = (stored >= 3 && mism1) || (stored == 6 && mism2);
            if (kind == 6) begin
               while (!err_pulse && cyc - c2 < 4 * TO) @(negedge clk);
               chk("read_timeout_cycles", cyc - c2, TO + 1);
               code = 3;
            end else begin
               if (!(sim && nb > 0)) begin
                  repeat ($urandom_range(1, 3)) @(negedge clk);
                  master_done = 1'b1; ack_error = ack_rd;
                  @(negedge clk);
                  master_done = 1'b0; ack_error = 1'b0;
               end
               code = fault ? 2 : ack_rd ? 1 : stored < 6 ? 3 : 0;
            end
            if (code == 0) begin
               m_temp = t; m_rh = h;
               chk("meas_valid", meas_valid, 1);
               chk("err_pulse_on_good", err_pulse, 0);
               chk("temp_raw", temp_raw, m_temp);
               chk("rh_raw", rh_raw, m_rh);
               @(negedge clk);
               chk("busy_after_done", busy, 0);
               chk("meas_valid_one_cycle", meas_valid, 0);
            end else finish_err(code);
         end
      end
      chk("proc_ready_pulses", pr_cnt - pr0, reached ? 2 : 1);
      chk("meas_pulses", mv_cnt - mv0, (reached && kind != 6 && !fault && !ack_rd && stored == 6) ? 1 : 0);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_proc_ready"}, proc_ready, 0);
      chk({tag, "_crc_error"}, crc_error, 0);
      chk({tag, "_meas_valid"}, meas_valid, 0);
      chk({tag, "_err_pulse"}, err_pulse, 0);
      chk({tag, "_temp"}, temp_raw, 16'h0000);
      chk({tag, "_rh"}, rh_raw, 16'h0000);
      chk({tag, "_err_code"}, err_code, 0);
      chk({tag, "_rw"}, r_or_w, 0);
      chk({tag, "_frame"}, command_data_frames, 8'h00);
      chk({tag, "_writes"}, i2c_writes, 1);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk_reset("reset");
      rst = 1'b0;
      @(negedge clk);
      for (int n = 0; n < 36; n++) run_txn(n < 9 ? n : $urandom_range(0, 8), n == 0);
      // asynchronous reset in the middle of a read that already has a CRC fault
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (2) @(negedge clk);
      master_done = 1'b1;
      @(negedge clk) master_done = 1'b0;
      for (int w = 0; w < 4 * MW && !proc_ready; w++) @(negedge clk);
      chk("rst_test_read_req", proc_ready, 1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         rx_valid = 1'b1; rx_byte = k == 0 ? 8'hBE : k == 1 ? 8'hEF : 8'h00;
         @(negedge clk) rx_valid = 1'b0;
      end
      chk("rst_test_crc_error", crc_error, 1);
      chk("rst_test_busy", busy, 1);
      #2 rst = 1'b1;
      #1 chk_reset("async_reset");
      @(negedge clk) rst = 1'b0;
      m_temp = 16'h0000; m_rh = 16'h0000;
      run_txn(0, 1'b1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/sht40_sequencer.md
Name: sht40_sequencer

Overview:
- Transaction sequencer that sits directly upstream of the i2c_master and drives one full SHT40 measurement cycle.
- Cycle: write measure command, wait out the conversion time, read 6 bytes, check both CRC-8s, publish raw temperature and humidity words.
- Supplies every control input the master needs (ready, address, frame, r/w, write/read counts, CRC abort) and consumes its received-byte stream.

Parameters:
- SHT_ADDR, 7'h44: sensor 7-bit I2C address.
- MEAS_CMD, 8'hFD: measure command (high precision).
- MEAS_WAIT, 20000: clk cycles between command-write completion and read start (10 ms at 2 MHz).
- TIMEOUT, 65535: max clk cycles from proc_ready to master_done before abort.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request for a measurement; ignored unless busy=0.
- proc_ready  out  1  one-cycle strobe launching a master transaction.
- peripheral_address  out  7  constant SHT_ADDR.
- command_data_frames  out  8  MEAS_CMD during the write transaction, 8'h00 otherwise.
- r_or_w  out  1  0 = write transaction, 1 = read transaction.
- i2c_writes  out  3  frames to write: 3'd1 for command, 3'd0 for read.
- sht_reads  out  4  master read terminal count: 4'd5 (6 bytes).
- crc_error  out  1  held high from CRC mismatch detection until master_done.
- master_done  in  1  one-cycle pulse when the master leaves its end state.
- ack_error  in  1  sampled with master_done; 1 = NACK occurred.
- rx_valid  in  1  one-cycle strobe, received byte is valid.
- rx_byte  in  8  received byte, MSB first on the bus.
- busy  out  1  high from accepted start until DONE/ERR exit.
- temp_raw  out  16  last good temperature word.
- rh_raw  out  16  last good humidity word.
- meas_valid  out  1  one-cycle pulse when temp_raw/rh_raw update.
- err_code  out  2  00 none, 01 NACK, 10 CRC, 11 timeout; valid with err_pulse.
- err_pulse  out  1  one-cycle pulse on transaction failure.

Behaviour:
- Reset (async, any state) clears the following:
  - state to IDLE.
  - busy, proc_ready, crc_error, meas_valid, err_pulse to 0.
  - temp_raw, rh_raw to 16'h0000; err_code to 2'b00.
  - r_or_w to 0; command_data_frames to 8'h00; all counters to 0.
- peripheral_address and sht_reads are constant; i2c_writes is 1 when r_or_w=0, else 0.
- States:
  - IDLE: start=1 → busy=1, r_or_w=0, frame=MEAS_CMD → CMD_REQ.
  - CMD_REQ: proc_ready=1 for exactly one cycle; load timeout counter → CMD_WAIT.
  - CMD_WAIT: on master_done with ack_error=0 → MEAS_WAIT; with ack_error=1 → ERR (code 01). Timeout counter reaching 0 → ERR (code 11).
  - MEAS_WAIT: count MEAS_WAIT cycles; at terminal count set r_or_w=1, frame=8'h00, byte index=0 → RD_REQ.
  - RD_REQ: proc_ready one cycle; reload timeout → RD_COLLECT.
  - RD_COLLECT: each rx_valid stores rx_byte at byte index 0..5, then index+1 (3-bit, no wrap past 5; strobes after index 5 are ignored).
  - DONE: commit temp_raw={b0,b1} and rh_raw={b3,b4} in the same cycle; meas_valid=1 one cycle; busy=0 → IDLE.
  - ERR: err_pulse=1 one cycle; busy=0; temp_raw/rh_raw unchanged → IDLE.
- RD_COLLECT exit rules:
  - On master_done: index=6, crc_error=0 and ack_error=0 → DONE.
  - crc_error already set → ERR (code 10).
  - ack_error=1 → ERR (code 01).
  - Index<6 without CRC fault → ERR (code 11).
  - Timeout → ERR (code 11).
- CRC-8 (SHT40 rule):
  - Polynomial 0x31, init 0xFF, no reflection, no final XOR.
  - Computed over {b0,b1} checked against b2, and over {b3,b4} checked against b5.
  - CRC update is combinational per byte, registered on rx_valid.
  - Mismatch is flagged (crc_error=1) in the cycle after the rx_valid of b2 or b5.
- Simultaneous events:
  - master_done and rx_valid in the same cycle: the byte is stored and CRC-checked first, then exit is evaluated on the updated index.
  - start while busy=1 is dropped.
  - Timeout expiry and master_done in the same cycle: master_done wins.
- Measurement latency is bounded only by master_done arrival and MEAS_WAIT; proc_ready is never reasserted while busy remains in a *_WAIT or COLLECT state.

Test Plan:
- Nominal read:
  - Stimulus: start; master_done ack_error=0; after 20000 cycles, bytes BE EF 92 66 66 93 then master_done.
  - Response: exactly two proc_ready pulses (r_or_w 0 then 1); meas_valid; temp_raw=16'hBEEF, rh_raw=16'h6666; err_pulse=0.
- CRC fault:
  - Stimulus: same read sequence, but byte 2 = 8'h93.
  - Response: crc_error=1 one cycle after that rx_valid; on master_done err_code=10, err_pulse=1; temp_raw keeps its prior value.
- NACK on command:
  - Stimulus: master_done with ack_error=1 in CMD_WAIT.
  - Response: err_code=01; no MEAS_WAIT delay and no second proc_ready.
- Timeout:
  - Stimulus: TIMEOUT=100; master_done never arrives.
  - Response: err_code=11 after 100 cycles; busy=0 next cycle.
- Short read:
  - Stimulus: master_done after 4 bytes.
  - Response: err_code=11.
- Start while busy, then reset:
  - Stimulus: start pulsed during MEAS_WAIT.
  - Response: ignored; exactly one measurement completes.
  - Stimulus: rst asserted mid-RD_COLLECT.
  - Response: all outputs return to reset values immediately (asynchronous).
